issue_queue_gen: RTL and testbench

//  Parametrised out-of-order issue queue, successor to the single-issue ALU queue.

---
 rtl/issq_pkg.sv | 36 +++
 rtl/issq_age_pick.sv | 28 ++
 rtl/issue_queue_gen.sv | 231 +++++++++++++++++++++++
 tb/tb_issue_queue_gen.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/issq_pkg.sv
// rtl/issq_pkg.sv - shared types, widths and age helper for the issue queue
package issq_pkg;

    localparam int ISSQ_PREG_W    = 6;
    localparam int ISSQ_ROB_W     = 6;
    localparam int ISSQ_PAYLOAD_W = 38;

    localparam logic [2:0] UOP_ALU = 3'd0;
    localparam logic [2:0] UOP_MUL = 3'd1;
    localparam logic [2:0] UOP_LSU = 3'd2;
    localparam logic [2:0] UOP_BR  = 3'd3;

    // Fields handed to an execute port unchanged.
    typedef struct packed {
        logic [ISSQ_PREG_W-1:0]    pj;
        logic [ISSQ_PREG_W-1:0]    pk;
        logic [ISSQ_PREG_W-1:0]    pd;
        logic                      regwr;
        logic [ISSQ_ROB_W-1:0]     tag;
        logic [ISSQ_PAYLOAD_W-1:0] payload;
    } issq_uop_t;

    // Queue entry: uop plus source readiness.
    typedef struct packed {
        issq_uop_t uop;
        logic      rdy_j;
        logic      rdy_k;
    } issq_entry_t;

    // Distance from the ROB head; smaller is older, wraps modulo 2^ROB_W.
    function automatic logic [ISSQ_ROB_W-1:0] rob_age(input logic [ISSQ_ROB_W-1:0] tag,
                                                      input logic [ISSQ_ROB_W-1:0] head);
        return tag - head;
    endfunction

endpackage

// File: rtl/issq_age_pick.sv
// rtl/issq_age_pick.sv - returns index of the minimum-age candidate, lowest index on ties
module issq_age_pick #(
    parameter int N     = 16,
    parameter int AGE_W = 6
) (
    input  logic [N-1:0]            cand,
    input  logic [N-1:0][AGE_W-1:0] age,
    output logic [$clog2(N)-1:0]    idx,
    output logic                    found
);

    logic [AGE_W-1:0] best_age;

    // Strict less-than while scanning upward keeps the lower index on equal ages.
    always_comb begin
        found    = 1'b0;
        idx      = '0;
        best_age = '0;
        for (int i = 0; i < N; i++) begin
            if (cand[i] && (!found || age[i] < best_age)) begin
                found    = 1'b1;
                best_age = age[i];
                idx      = ($clog2(N))'(i);
            end
        end
    end

endmodule

// File: rtl/issue_queue_gen.sv
// rtl/issue_queue_gen.sv - out-of-order issue queue, oldest-first multi-port issue; optional ISSQ_SEL_FLUSH_EN selective kill
module issue_queue_gen
    import issq_pkg::*;
#(
    parameter int         DEPTH     = 16,
    parameter int         DISP_W    = 3,
    parameter int         ISSUE_W   = 2,
    parameter int         CDB_N     = 5,
    parameter logic [2:0] TYPE_CODE = UOP_ALU
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   flush,
    input  logic                                   stall_in,
    output logic                                   full,
    input  logic [DISP_W-1:0]                      disp_valid,
    input  logic [DISP_W-1:0][2:0]                 disp_type,
    input  logic [DISP_W-1:0][ISSQ_PREG_W-1:0]     disp_pj,
    input  logic [DISP_W-1:0][ISSQ_PREG_W-1:0]     disp_pk,
    input  logic [DISP_W-1:0]                      disp_pj_rdy,
    input  logic [DISP_W-1:0]                      disp_pk_rdy,
    input  logic [DISP_W-1:0]                      disp_is_imm,
    input  logic [DISP_W-1:0][ISSQ_PREG_W-1:0]     disp_pd,
    input  logic [DISP_W-1:0]                      disp_regwr,
    input  logic [DISP_W-1:0][ISSQ_ROB_W-1:0]      disp_tag,
    input  logic [DISP_W-1:0][ISSQ_PAYLOAD_W-1:0]  disp_payload,
    input  logic [ISSQ_ROB_W-1:0]                  rob_ptr_old,
    input  logic [CDB_N-1:0]                       cdb_valid,
    input  logic [CDB_N-1:0]                       cdb_regwr,
    input  logic [CDB_N-1:0][ISSQ_PREG_W-1:0]      cdb_pd,
    input  logic [ISSUE_W-1:0]                     iss_stall,
    output logic [ISSUE_W-1:0]                     iss_valid,
    output logic [ISSUE_W-1:0][ISSQ_PREG_W-1:0]    iss_pj,
    output logic [ISSUE_W-1:0][ISSQ_PREG_W-1:0]    iss_pk,
    output logic [ISSUE_W-1:0][ISSQ_PREG_W-1:0]    iss_pd,
    output logic [ISSUE_W-1:0]                     iss_regwr,
    output logic [ISSUE_W-1:0][ISSQ_ROB_W-1:0]     iss_tag,
    output logic [ISSUE_W-1:0][ISSQ_PAYLOAD_W-1:0] iss_payload,
`ifdef ISSQ_SEL_FLUSH_EN
    input  logic                                   kill_valid,
    input  logic [ISSQ_ROB_W-1:0]                  kill_tag,
`endif
    output logic [$clog2(DEPTH):0]                 free_cnt
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    issq_entry_t                       ent_q [DEPTH];
    issq_entry_t                       ent_d [DEPTH];
    logic [DEPTH-1:0]                  valid_q, valid_d;
    issq_uop_t                         iss_q [ISSUE_W];
    issq_uop_t                         iss_d [ISSUE_W];
    logic [ISSUE_W-1:0]                iss_valid_q, iss_valid_d;
    logic [CNT_W-1:0]                  free_cnt_q, free_cnt_d;

    logic [DEPTH-1:0][ISSQ_ROB_W-1:0]  age;
    logic [DEPTH-1:0]                  cand;
    logic [IDX_W-1:0]                  pick_idx   [ISSUE_W];
    logic                              pick_found [ISSUE_W];

    logic [DEPTH-1:0]                  free_list;
    logic                              disp_en;
    logic                              placed;
    logic                              hit_j, hit_k;
    issq_entry_t                       new_ent;
    logic [CNT_W-1:0]                  used_cnt;

    assign full     = free_cnt_q < CNT_W'(DISP_W);
    assign free_cnt = free_cnt_q;

    // Age and issue eligibility from registered state only, so same-cycle wakeups wait a cycle.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            age[i]  = rob_age(ent_q[i].uop.tag, rob_ptr_old);
            cand[i] = valid_q[i] & ent_q[i].rdy_j & ent_q[i].rdy_k;
        end
    end

    // Port k chooses among candidates not taken by ports below it; a stalled port takes nothing.
    for (genvar k = 0; k < ISSUE_W; k++) begin : g_port
        logic [DEPTH-1:0] m_in;
        logic [DEPTH-1:0] m_out;
        logic [IDX_W-1:0] idx;
        logic             found;

        if (k == 0) begin : g_first
            assign m_in = cand;
        end else begin : g_next
            assign m_in = g_port[k-1].m_out;
        end

        issq_age_pick #(.N(DEPTH), .AGE_W(ISSQ_ROB_W)) u_pick (
            .cand  (m_in & {DEPTH{~iss_stall[k]}}),
            .age   (age),
            .idx   (idx),
            .found (found)
        );

        assign m_out         = m_in & ~(found ? ({{(DEPTH-1){1'b0}}, 1'b1} << idx) : '0);
        assign pick_idx[k]   = idx;
        assign pick_found[k] = found;
    end

    // Next state: wakeup, issue, dispatch, then optional kill and flush which override.
    always_comb begin
        ent_d       = ent_q;
        valid_d     = valid_q;
        iss_d       = iss_q;
        iss_valid_d = iss_valid_q;
        free_list   = ~valid_q;
        placed      = 1'b0;
        hit_j       = 1'b0;
        hit_k       = 1'b0;
        new_ent     = '0;
        used_cnt    = '0;
        disp_en     = !full && !stall_in;
`ifdef ISSQ_SEL_FLUSH_EN
        disp_en     = disp_en && !kill_valid;
`endif

        for (int i = 0; i < DEPTH; i++) begin
            for (int c = 0; c < CDB_N; c++) begin
                if (valid_q[i] && cdb_valid[c] && cdb_regwr[c]) begin
                    if (ent_q[i].uop.pj == cdb_pd[c]) ent_d[i].rdy_j = 1'b1;
                    if (ent_q[i].uop.pk == cdb_pd[c]) ent_d[i].rdy_k = 1'b1;
                end
            end
        end

        for (int k = 0; k < ISSUE_W; k++) begin
            if (!iss_stall[k]) begin
                if (pick_found[k]) begin
                    iss_d[k]                = ent_q[pick_idx[k]].uop;
                    iss_valid_d[k]          = 1'b1;
                    valid_d[pick_idx[k]]    = 1'b0;
                end else begin
                    iss_d[k]       = '0;
                    iss_valid_d[k] = 1'b0;
                end
            end
        end

        for (int s = 0; s < DISP_W; s++) begin
            if (disp_en && disp_valid[s] && disp_type[s] == TYPE_CODE) begin
                hit_j = 1'b0;
                hit_k = 1'b0;
                for (int c = 0; c < CDB_N; c++) begin
                    if (cdb_valid[c] && cdb_regwr[c] && cdb_pd[c] == disp_pj[s]) hit_j = 1'b1;
                    if (cdb_valid[c] && cdb_regwr[c] && cdb_pd[c] == disp_pk[s]) hit_k = 1'b1;
                end
                new_ent.uop.pj      = disp_pj[s];
                new_ent.uop.pk      = disp_pk[s];
                new_ent.uop.pd      = disp_pd[s];
                new_ent.uop.regwr   = disp_regwr[s];
                new_ent.uop.tag     = disp_tag[s];
                new_ent.uop.payload = disp_payload[s];
                new_ent.rdy_j       = disp_pj_rdy[s] | hit_j;
                new_ent.rdy_k       = disp_pk_rdy[s] | disp_is_imm[s] | hit_k;
                placed              = 1'b0;
                for (int i = 0; i < DEPTH; i++) begin
                    if (!placed && free_list[i]) begin
                        ent_d[i]     = new_ent;
                        valid_d[i]   = 1'b1;
                        free_list[i] = 1'b0;
                        placed       = 1'b1;
                    end
                end
            end
        end

`ifdef ISSQ_SEL_FLUSH_EN
        if (kill_valid) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (rob_age(ent_d[i].uop.tag, rob_ptr_old) > rob_age(kill_tag, rob_ptr_old))
                    valid_d[i] = 1'b0;
            end
            for (int k = 0; k < ISSUE_W; k++) begin
                if (rob_age(iss_d[k].tag, rob_ptr_old) > rob_age(kill_tag, rob_ptr_old)) begin
                    iss_d[k]       = '0;
                    iss_valid_d[k] = 1'b0;
                end
            end
        end
`endif

        if (flush) begin
            valid_d     = '0;
            iss_valid_d = '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_d[i].rdy_j = 1'b0;
                ent_d[i].rdy_k = 1'b0;
            end
            for (int k = 0; k < ISSUE_W; k++) iss_d[k] = '0;
        end

        for (int i = 0; i < DEPTH; i++) used_cnt = used_cnt + CNT_W'(valid_d[i]);
        free_cnt_d = CNT_W'(DEPTH) - used_cnt;
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q     <= '0;
            iss_valid_q <= '0;
            free_cnt_q  <= CNT_W'(DEPTH);
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
            for (int k = 0; k < ISSUE_W; k++) iss_q[k] <= '0;
        end else begin
            valid_q     <= valid_d;
            iss_valid_q <= iss_valid_d;
            free_cnt_q  <= free_cnt_d;
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
            for (int k = 0; k < ISSUE_W; k++) iss_q[k] <= iss_d[k];
        end
    end

    // Issue register fields onto the output ports.
    always_comb begin
        iss_valid = iss_valid_q;
        for (int k = 0; k < ISSUE_W; k++) begin
            iss_pj[k]      = iss_q[k].pj;
            iss_pk[k]      = iss_q[k].pk;
            iss_pd[k]      = iss_q[k].pd;
            iss_regwr[k]   = iss_q[k].regwr;
            iss_tag[k]     = iss_q[k].tag;
            iss_payload[k] = iss_q[k].payload;
        end
    end

endmodule

// File: tb/tb_issue_queue_gen.sv
// tb/tb_issue_queue_gen.sv - directed scoreboard bench for issue_queue_gen
module tb_issue_queue_gen;

    logic             clk = 1'b0;
    logic             rst, flush, stall_in, full;
    logic [2:0]       disp_valid, disp_pj_rdy, disp_pk_rdy, disp_is_imm, disp_regwr;
    logic [2:0][2:0]  disp_type;
    logic [2:0][5:0]  disp_pj, disp_pk, disp_pd, disp_tag;
    logic [2:0][37:0] disp_payload;
    logic [5:0]       rob_ptr_old;
    logic [4:0]       cdb_valid, cdb_regwr;
    logic [4:0][5:0]  cdb_pd;
    logic [1:0]       iss_stall, iss_valid, iss_regwr;
    logic [1:0][5:0]  iss_pj, iss_pk, iss_pd, iss_tag;
    logic [1:0][37:0] iss_payload;
    logic [4:0]       free_cnt;
`ifdef ISSQ_SEL_FLUSH_EN
    logic             kill_valid;
    logic [5:0]       kill_tag;
`endif

    typedef struct {
        int          port;
        logic [5:0]  tag, pj, pk, pd;
        logic        regwr;
        logic [37:0] payload;
    } exp_t;

    exp_t       sb[$];
    int         errors = 0;
    int         checks = 0;
    logic [1:0] stall_prev;

    issue_queue_gen dut (
        .clk(clk), .rst(rst), .flush(flush), .stall_in(stall_in), .full(full),
        .disp_valid(disp_valid), .disp_type(disp_type), .disp_pj(disp_pj), .disp_pk(disp_pk),
        .disp_pj_rdy(disp_pj_rdy), .disp_pk_rdy(disp_pk_rdy), .disp_is_imm(disp_is_imm),
        .disp_pd(disp_pd), .disp_regwr(disp_regwr), .disp_tag(disp_tag),
        .disp_payload(disp_payload), .rob_ptr_old(rob_ptr_old),
        .cdb_valid(cdb_valid), .cdb_regwr(cdb_regwr), .cdb_pd(cdb_pd),
        .iss_stall(iss_stall), .iss_valid(iss_valid), .iss_pj(iss_pj), .iss_pk(iss_pk),
        .iss_pd(iss_pd), .iss_regwr(iss_regwr), .iss_tag(iss_tag), .iss_payload(iss_payload),
`ifdef ISSQ_SEL_FLUSH_EN
        .kill_valid(kill_valid), .kill_tag(kill_tag),
`endif
        .free_cnt(free_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [37:0] pay(input logic [5:0] tag, input logic [5:0] pd);
        return {26'h2A5A5A5, tag, pd};
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic set_slot(input int s, input logic [2:0] typ, input logic [5:0] pj, input logic pjr,
                            input logic [5:0] pk, input logic pkr, input logic imm,
                            input logic rw, input logic [5:0] tag);
        disp_valid[s]   = 1'b1;
        disp_type[s]    = typ;
        disp_pj[s]      = pj;
        disp_pj_rdy[s]  = pjr;
        disp_pk[s]      = pk;
        disp_pk_rdy[s]  = pkr;
        disp_is_imm[s]  = imm;
        disp_pd[s]      = tag ^ 6'h20;
        disp_regwr[s]   = rw;
        disp_tag[s]     = tag;
        disp_payload[s] = pay(tag, tag ^ 6'h20);
    endtask

    task automatic push(input int port, input logic [5:0] tag, input logic [5:0] pj,
                        input logic [5:0] pk, input logic rw);
        exp_t e;
        e.port = port; e.tag = tag; e.pj = pj; e.pk = pk; e.pd = tag ^ 6'h20;
        e.regwr = rw; e.payload = pay(tag, tag ^ 6'h20);
        sb.push_back(e);
    endtask

    task automatic clr_disp();
        disp_valid = '0; disp_type = '0; disp_pj = '0; disp_pk = '0; disp_pj_rdy = '0;
        disp_pk_rdy = '0; disp_is_imm = '0; disp_pd = '0; disp_regwr = '0; disp_tag = '0;
        disp_payload = '0;
    endtask

    task automatic clr_cdb();
        cdb_valid = '0; cdb_regwr = '0; cdb_pd = '0;
    endtask

    task automatic cdb(input int p, input logic [5:0] pd, input logic rw);
        cdb_valid[p] = 1'b1; cdb_regwr[p] = rw; cdb_pd[p] = pd;
    endtask

    // One clock; every newly loaded issue register is matched against the scoreboard head.
    task automatic tick();
        exp_t e;
        stall_prev = iss_stall;
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            if (!stall_prev[k] && iss_valid[k]) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $error("FAIL unexpected_issue: port %0d observed tag=%0d, expected no issue", k, iss_tag[k]);
                end else begin
                    e = sb.pop_front();
                    chk("iss_port", 64'(k), 64'(e.port));
                    chk("iss_tag", iss_tag[k], e.tag);
                    chk("iss_pj", iss_pj[k], e.pj);
                    chk("iss_pk", iss_pk[k], e.pk);
                    chk("iss_pd", iss_pd[k], e.pd);
                    chk("iss_regwr", iss_regwr[k], e.regwr);
                    chk("iss_payload", iss_payload[k], e.payload);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; stall_in = 1'b0; iss_stall = '0; rob_ptr_old = '0;
`ifdef ISSQ_SEL_FLUSH_EN
        kill_valid = 1'b0; kill_tag = '0;
`endif
        clr_disp(); clr_cdb();
        tick(); tick();
        chk("rst_free_cnt", free_cnt, 16);
        chk("rst_full", full, 0);
        chk("rst_iss_valid", iss_valid, 0);
        chk("rst_iss_tag", iss_tag, 0);
        chk("rst_iss_payload", iss_payload, 0);
        rst = 1'b0;
        tick();

        // Oldest-first across two ports.
        set_slot(0, 3'd0, 6'd1, 1, 6'd2, 1, 0, 1, 6'd5);
        set_slot(1, 3'd0, 6'd1, 1, 6'd2, 1, 0, 1, 6'd3);
        set_slot(2, 3'd0, 6'd1, 1, 6'd2, 1, 0, 1, 6'd4);
        push(0, 6'd3, 6'd1, 6'd2, 1); push(1, 6'd4, 6'd1, 6'd2, 1); push(0, 6'd5, 6'd1, 6'd2, 1);
        tick(); clr_disp();
        chk("t1_free_after_disp", free_cnt, 13);
        chk("t1_no_issue_yet", iss_valid, 2'b00);
        tick();
        chk("t1_both_ports", iss_valid, 2'b11);
        chk("t1_free_after_issue", free_cnt, 15);
        tick();
        chk("t1_third", iss_valid, 2'b01);
        tick();
        chk("t1_idle", iss_valid, 2'b00);
        chk("t1_free_end", free_cnt, 16);
        chk("t1_sb_empty", sb.size(), 0);

        // Wakeup via CDB; non-regwr broadcast must not wake.
        set_slot(0, 3'd0, 6'd12, 0, 6'd0, 1, 0, 1, 6'd6);
        push(0, 6'd6, 6'd12, 6'd0, 1);
        tick(); clr_disp();
        cdb(0, 6'd12, 1'b0);
        tick(); clr_cdb();
        chk("t2_no_wake_regwr0", iss_valid, 2'b00);
        cdb(2, 6'd12, 1'b1);
        tick(); clr_cdb();
        chk("t2_wake_not_same_cycle", iss_valid, 2'b00);
        tick();
        chk("t2_issued", iss_valid, 2'b01);
        chk("t2_sb_empty", sb.size(), 0);

        // Same-cycle CDB at dispatch, immediate Pk, wrong-type slot ignored.
        set_slot(0, 3'd0, 6'd2, 1, 6'd7, 0, 0, 1, 6'd7);
        set_slot(1, 3'd1, 6'd2, 1, 6'd3, 1, 0, 1, 6'd8);
        set_slot(2, 3'd0, 6'd3, 1, 6'd9, 0, 1, 0, 6'd9);
        cdb(4, 6'd7, 1'b1);
        push(0, 6'd7, 6'd2, 6'd7, 1); push(1, 6'd9, 6'd3, 6'd9, 0);
        tick(); clr_disp(); clr_cdb();
        chk("t3_free", free_cnt, 14);
        tick();
        chk("t3_both", iss_valid, 2'b11);
        tick();
        chk("t3_idle", iss_valid, 2'b00);
        chk("t3_free_end", free_cnt, 16);

        // stall_in blocks dispatch; fill to 14 entries; full blocks dispatch.
        stall_in = 1'b1;
        for (int s = 0; s < 3; s++) set_slot(s, 3'd0, 6'd1, 1, 6'd2, 1, 0, 1, 6'(50 + s));
        tick(); clr_disp(); stall_in = 1'b0;
        chk("t4_stall_in", free_cnt, 16);
        for (int b = 0; b < 5; b++) begin
            for (int s = 0; s < ((b < 4) ? 3 : 2); s++)
                set_slot(s, 3'd0, 6'd40, 0, 6'd0, 1, 0, 1, 6'(10 + 3 * b + s));
            tick(); clr_disp();
            if (b == 3) begin
                chk("t4_free_4", free_cnt, 4);
                chk("t4_not_full_4", full, 0);
            end
        end
        chk("t4_free_2", free_cnt, 2);
        chk("t4_full", full, 1);
        for (int s = 0; s < 3; s++) set_slot(s, 3'd0, 6'd1, 1, 6'd2, 1, 0, 1, 6'(50 + s));
        tick(); clr_disp();
        chk("t4_full_ignored", free_cnt, 2);
        chk("t4_no_issue", iss_valid, 2'b00);
        for (int t = 0; t < 14; t++) push(t % 2, 6'(10 + t), 6'd40, 6'd0, 1);
        cdb(1, 6'd40, 1'b1);
        tick(); clr_cdb();
        for (int t = 0; t < 8; t++) tick();
        chk("t4_free_end", free_cnt, 16);
        chk("t4_sb_empty", sb.size(), 0);

        // Port 0 stalled for three cycles: held register, traffic moves to port 1.
        set_slot(0, 3'd0, 6'd1, 1, 6'd2, 1, 0, 1, 6'd29);
        push(0, 6'd29, 6'd1, 6'd2, 1);
        tick(); clr_disp();
        tick();
        chk("t5_loaded", iss_tag[0], 29);
        iss_stall = 2'b01;
        for (int s = 0; s < 3; s++) set_slot(s, 3'd0, 6'd1, 1, 6'd2, 1, 0, 1, 6'(30 + s));
        push(1, 6'd30, 6'd1, 6'd2, 1); push(1, 6'd31, 6'd1, 6'd2, 1); push(0, 6'd32, 6'd1, 6'd2, 1);
        tick(); clr_disp();
        for (int c = 0; c < 2; c++) begin
            tick();
            chk("t5_hold_valid", iss_valid[0], 1);
            chk("t5_hold_tag", iss_tag[0], 29);
            chk("t5_hold_payload", iss_payload[0], pay(6'd29, 6'd29 ^ 6'h20));
        end
        iss_stall = 2'b00;
        tick();
        tick();
        chk("t5_sb_empty", sb.size(), 0);

        // Age wrap around the ROB head.
        rob_ptr_old = 6'd60;
        set_slot(0, 3'd0, 6'd1, 1, 6'd2, 1, 0, 1, 6'd1);
        set_slot(1, 3'd0, 6'd1, 1, 6'd2, 1, 0, 1, 6'd62);
        set_slot(2, 3'd0, 6'd1, 1, 6'd2, 1, 0, 1, 6'd0);
        push(0, 6'd62, 6'd1, 6'd2, 1); push(1, 6'd0, 6'd1, 6'd2, 1); push(0, 6'd1, 6'd1, 6'd2, 1);
        tick(); clr_disp();
        tick(); tick(); tick();
        chk("t6_sb_empty", sb.size(), 0);

`ifdef ISSQ_SEL_FLUSH_EN
        // Selective kill removes entries younger than kill_tag and suppresses dispatch.
        set_slot(0, 3'd0, 6'd55, 0, 6'd2, 1, 0, 1, 6'd62);
        set_slot(1, 3'd0, 6'd55, 0, 6'd2, 1, 0, 1, 6'd1);
        tick(); clr_disp();
        kill_valid = 1'b1; kill_tag = 6'd62;
        set_slot(0, 3'd0, 6'd1, 1, 6'd2, 1, 0, 1, 6'd2);
        tick(); clr_disp(); kill_valid = 1'b0;
        chk("k_free", free_cnt, 15);
        push(0, 6'd62, 6'd55, 6'd2, 1);
        cdb(0, 6'd55, 1'b1);
        tick(); clr_cdb();
        tick(); tick();
        chk("k_sb_empty", sb.size(), 0);
        chk("k_free_end", free_cnt, 16);
`endif

        // Flush clears entries and issue registers and overrides dispatch.
        rob_ptr_old = 6'd0;
        set_slot(0, 3'd0, 6'd1, 1, 6'd2, 1, 0, 1, 6'd40);
        set_slot(1, 3'd0, 6'd50, 0, 6'd2, 1, 0, 1, 6'd41);
        set_slot(2, 3'd0, 6'd50, 0, 6'd2, 1, 0, 1, 6'd42);
        push(0, 6'd40, 6'd1, 6'd2, 1);
        tick(); clr_disp();
        tick();
        chk("t7_loaded", iss_valid, 2'b01);
        iss_stall = 2'b11; flush = 1'b1;
        set_slot(0, 3'd0, 6'd1, 1, 6'd2, 1, 0, 1, 6'd43);
        tick(); clr_disp(); flush = 1'b0; iss_stall = 2'b00;
        chk("t7_flush_valid", iss_valid, 2'b00);
        chk("t7_flush_tag", iss_tag[0], 0);
        chk("t7_flush_free", free_cnt, 16);
        chk("t7_flush_full", full, 0);
        cdb(3, 6'd50, 1'b1);
        tick(); clr_cdb();
        tick(); tick();
        chk("t7_nothing_after_flush", iss_valid, 2'b00);
        chk("t7_sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
